// File: rtl/arm_pkg.sv
// Shared types for the ARM execute stage: ALU opcodes, condition codes,
// forwarding selects, the NZCV flag bundle and the multiply FSM states.
package arm_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC,
    COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT,
    COND_GT, COND_LE, COND_AL, COND_NV
  } cond_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    S_IDLE,
    S_MUL1
  } mul_state_t;

endpackage

// File: rtl/cond_unit.sv
// ARM condition evaluation against the NZCV register it owns; flag updates
// are applied only when the instruction's condition passes.
module cond_unit
  import arm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] flag_write,
  input  flags_t     alu_flags,
  output logic       cond_ex
);

  flags_t flags;
  flags_t flags_next;

  always_comb begin
    cond_ex = 1'b1;
    case (cond_t'(cond))
      COND_EQ: cond_ex = flags.z;
      COND_NE: cond_ex = !flags.z;
      COND_CS: cond_ex = flags.c;
      COND_CC: cond_ex = !flags.c;
      COND_MI: cond_ex = flags.n;
      COND_PL: cond_ex = !flags.n;
      COND_VS: cond_ex = flags.v;
      COND_VC: cond_ex = !flags.v;
      COND_HI: cond_ex = flags.c && !flags.z;
      COND_LS: cond_ex = !flags.c || flags.z;
      COND_GE: cond_ex = (flags.n == flags.v);
      COND_LT: cond_ex = (flags.n != flags.v);
      COND_GT: cond_ex = !flags.z && (flags.n == flags.v);
      COND_LE: cond_ex = flags.z || (flags.n != flags.v);
      default: cond_ex = 1'b1;
    endcase
  end

  always_comb begin
    flags_next = flags;
    if (flag_write[1] && cond_ex) begin
      flags_next.n = alu_flags.n;
      flags_next.z = alu_flags.z;
    end
    if (flag_write[0] && cond_ex) begin
      flags_next.c = alu_flags.c;
      flags_next.v = alu_flags.v;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) flags <= '0;
    else        flags <= flags_next;
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU with a 2-cycle multiply, condition gating
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage
  import arm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             FlushE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             ALUSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemToRegE,
  input  logic             PlusOneE,
  input  logic [3:0]       WA3E,
  output logic             BusyE,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemToRegM,
  output logic             PlusOneM
);

  logic [WIDTH-1:0] src_a, write_data, src_b, b_in, alu_res, prod, res_e;
  logic [WIDTH-1:0] mul_p, mul_wd;
  logic [WIDTH:0]   sum;
  alu_op_t          op;
  logic             is_sub, is_mul, arith;
  logic             cond_ex;
  flags_t           alu_flags;
  logic [1:0]       flag_we;
  mul_state_t       state, state_next;

  always_comb begin
    case (fwd_sel_t'(ForwardAE))
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUOutM;
      default: src_a = RD1E;
    endcase
    case (fwd_sel_t'(ForwardBE))
      FWD_WB:  write_data = ResultW;
      FWD_MEM: write_data = ALUOutM;
      default: write_data = RD2E;
    endcase
    src_b = ALUSrcE ? ExtImmE : write_data;
  end

  always_comb begin
    op = alu_op_t'(ALUControlE);
    if (!MUL_EN && op == ALU_MUL) op = ALU_ADD;
    is_sub = (op == ALU_SUB);
    is_mul = (op == ALU_MUL);
    arith  = (op == ALU_ADD) || (op == ALU_SUB);
    b_in   = is_sub ? ~src_b : src_b;
    sum    = {1'b0, src_a} + {1'b0, b_in} + {{WIDTH{1'b0}}, is_sub};
    prod   = src_a * src_b;
    case (op)
      ALU_AND: alu_res = src_a & src_b;
      ALU_ORR: alu_res = src_a | src_b;
      ALU_MUL: alu_res = prod;
      default: alu_res = sum[WIDTH-1:0];
    endcase
  end

  // In MUL1 the result (and its N/Z) comes from the captured product.
  assign res_e       = (state == S_MUL1) ? mul_p : alu_res;
  assign alu_flags.n = res_e[WIDTH-1];
  assign alu_flags.z = (res_e == '0);
  assign alu_flags.c = sum[WIDTH];
  assign alu_flags.v = (src_a[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);

  assign BusyE = MUL_EN && (state == S_IDLE) && is_mul && cond_ex && !FlushE;

  assign flag_we[1] = FlagWriteE[1] && !FlushE && !BusyE;
  assign flag_we[0] = FlagWriteE[0] && !FlushE && !BusyE && arith;

  cond_unit u_cond (
    .clock      (clock),
    .reset      (reset),
    .cond       (CondE),
    .flag_write (flag_we),
    .alu_flags  (alu_flags),
    .cond_ex    (cond_ex)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (BusyE) state_next = S_MUL1;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_IDLE;
      mul_p  <= '0;
      mul_wd <= '0;
    end else begin
      state <= state_next;
      if (BusyE) begin
        mul_p  <= prod;
        mul_wd <= write_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || FlushE || BusyE) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      PlusOneM   <= 1'b0;
    end else begin
      ALUOutM    <= res_e;
      WriteDataM <= (state == S_MUL1) ? mul_wd : write_data;
      WA3M       <= WA3E;
      PCSrcM     <= PCSrcE && cond_ex;
      RegWriteM  <= RegWriteE && cond_ex;
      MemWriteM  <= MemWriteE && cond_ex;
      MemToRegM  <= MemToRegE;
      PlusOneM   <= PlusOneE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected M-stage
// state; a monitor pops and compares one entry after every clock edge.
module tb_execute_stage;

  typedef logic [76:0] exp_t; // {alu, wd, wa3, pcs, rw, mw, m2r, p1, nzcv}

  logic        clock = 1'b0;
  logic        reset;
  logic        FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] RD1E, RD2E, ExtImmE, ResultW;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  CondE;
  logic        PCSrcE, RegWriteE, MemWriteE, MemToRegE, PlusOneE;
  logic [3:0]  WA3E;
  logic        BusyE;
  logic [31:0] ALUOutM, WriteDataM;
  logic [3:0]  WA3M;
  logic        PCSrcM, RegWriteM, MemWriteM, MemToRegM, PlusOneM;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  execute_stage #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ResultW(ResultW),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemToRegE(MemToRegE), .PlusOneE(PlusOneE), .WA3E(WA3E),
    .BusyE(BusyE), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemToRegM(MemToRegM), .PlusOneM(PlusOneM)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] wa, input logic [4:0] c,
                              input logic [3:0] f);
    return {a, w, wa, c, f};
  endfunction

  task automatic defaults();
    FlushE = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    RD1E = 0; RD2E = 0; ExtImmE = 0; ResultW = 0;
    ALUSrcE = 0; ALUControlE = 3'b000; FlagWriteE = 2'b00; CondE = 4'hE;
    PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemToRegE = 0; PlusOneE = 0;
    WA3E = 0;
  endtask

  // Inputs are already applied at the falling edge when this is called.
  task automatic step(input string name, input logic exp_busy, input exp_t e);
    #1;
    compared++;
    if (BusyE !== exp_busy) begin
      mismatched++;
      $display("FAIL busy %s: got %b expected %b", name, BusyE, exp_busy);
    end
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  initial begin : monitor
    int   idx;
    exp_t e, act;
    idx = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {ALUOutM, WriteDataM, WA3M, PCSrcM, RegWriteM, MemWriteM,
               MemToRegM, PlusOneM, 4'(dut.u_cond.flags)};
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL mout[%0d]: got alu=%h wd=%h wa3=%h ctl=%b nzcv=%b, expected alu=%h wd=%h wa3=%h ctl=%b nzcv=%b",
                   idx, act[76:45], act[44:13], act[12:9], act[8:4], act[3:0],
                   e[76:45], e[44:13], e[12:9], e[8:4], e[3:0]);
        end
        idx++;
      end
    end
  end

  initial begin
    defaults();
    reset = 0;
    RD1E = 5; RD2E = 7; RegWriteE = 1; WA3E = 3;
    step("reset", 0, mk(0, 0, 0, 5'b00000, 4'b0000));
    reset = 1;

    defaults(); RD1E = 5; RD2E = 7; RegWriteE = 1; WA3E = 3;
    step("add", 0, mk(32'd12, 32'd7, 4'd3, 5'b01000, 4'b0000));
    defaults(); ALUControlE = 3'b001; RD1E = 3; RD2E = 3; FlagWriteE = 2'b11; RegWriteE = 1; WA3E = 4;
    step("sub_z", 0, mk(0, 32'd3, 4'd4, 5'b01000, 4'b0110));
    defaults(); CondE = 4'b0000; MemWriteE = 1; RD1E = 1; RD2E = 2;
    step("eq_pass", 0, mk(32'd3, 32'd2, 0, 5'b00100, 4'b0110));
    defaults(); CondE = 4'b0001; MemWriteE = 1; RegWriteE = 1; PCSrcE = 1; MemToRegE = 1; PlusOneE = 1;
    RD1E = 1; RD2E = 2; FlagWriteE = 2'b11;
    step("ne_fail", 0, mk(32'd3, 32'd2, 0, 5'b00011, 4'b0110));
    defaults(); RD1E = 32'h7FFF_FFFF; RD2E = 1; FlagWriteE = 2'b11;
    step("add_ovf", 0, mk(32'h8000_0000, 32'd1, 0, 5'b00000, 4'b1001));
    defaults(); CondE = 4'b0110; RegWriteE = 1; RD1E = 32'hF; RD2E = 1;
    step("vs_pass", 0, mk(32'h10, 32'd1, 0, 5'b01000, 4'b1001));
    defaults(); CondE = 4'b0111; RegWriteE = 1; RD1E = 32'hF; RD2E = 1;
    step("vc_fail", 0, mk(32'h10, 32'd1, 0, 5'b00000, 4'b1001));
    defaults(); ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20;
    step("fwd_mem_wb", 0, mk(32'h30, 32'h20, 0, 5'b00000, 4'b1001));
    defaults(); ForwardAE = 2'b01; ForwardBE = 2'b01; ResultW = 32'h20; ALUSrcE = 1;
    ExtImmE = 32'h100; RD2E = 5;
    step("fwd_imm", 0, mk(32'h120, 32'h20, 0, 5'b00000, 4'b1001));
    defaults(); ALUControlE = 3'b010; RD1E = 32'hF0F0; RD2E = 32'hFF00; FlagWriteE = 2'b11;
    step("and_keep_cv", 0, mk(32'hF000, 32'hFF00, 0, 5'b00000, 4'b0001));
    defaults(); ALUControlE = 3'b011; RD1E = 32'h0F; RD2E = 32'hF0;
    step("orr", 0, mk(32'hFF, 32'hF0, 0, 5'b00000, 4'b0001));
    defaults(); ALUControlE = 3'b001; RD1E = 5; RD2E = 5; FlagWriteE = 2'b11;
    step("sub_pre_mul", 0, mk(0, 32'd5, 0, 5'b00000, 4'b0110));

    defaults(); ALUControlE = 3'b100; RD1E = 6; RD2E = 7; FlagWriteE = 2'b10; RegWriteE = 1; WA3E = 5;
    step("mul_issue", 1, mk(0, 0, 0, 5'b00000, 4'b0110));
    step("mul_done", 0, mk(32'd42, 32'd7, 4'd5, 5'b01000, 4'b0010));
    defaults(); ALUControlE = 3'b100; RD1E = 3; RD2E = 4; FlagWriteE = 2'b10; RegWriteE = 1;
    step("mul2_issue", 1, mk(0, 0, 0, 5'b00000, 4'b0010));
    FlushE = 1;
    step("mul2_flush", 0, mk(0, 0, 0, 5'b00000, 4'b0010));
    defaults(); RD1E = 1; RD2E = 1; RegWriteE = 1;
    step("after_flush", 0, mk(32'd2, 32'd1, 0, 5'b01000, 4'b0010));
    defaults(); ALUControlE = 3'b100; CondE = 4'b0000; RD1E = 3; RD2E = 5; RegWriteE = 1; FlagWriteE = 2'b10;
    step("mul_cond_fail", 0, mk(32'd15, 32'd5, 0, 5'b00000, 4'b0010));

    defaults(); ALUControlE = 3'b100; RD1E = 2; RD2E = 3; FlagWriteE = 2'b10; RegWriteE = 1; WA3E = 7;
    step("mul3_issue", 1, mk(0, 0, 0, 5'b00000, 4'b0010));
    reset = 0;
    step("reset_mul1", 0, mk(0, 0, 0, 5'b00000, 4'b0000));
    reset = 1;
    defaults(); RD1E = 5; RD2E = 7; RegWriteE = 1; WA3E = 3;
    step("add_after_rst", 0, mk(32'd12, 32'd7, 4'd3, 5'b01000, 4'b0000));

    defaults();
    repeat (3) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
EX stage of the 5-stage ARM pipeline, directly upstream of the memory stage.
- Selects forwarded operands and runs the ALU, including a 2-cycle multiply.
- Evaluates the ARM condition field against an internal NZCV flags register.
- Owns the EX/MEM pipeline register that drives the memory stage's inputs.

Parameters:
WIDTH, 32, datapath width
MUL_EN, 1, 1 = MUL opcode supported; 0 = MUL decodes as ADD

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
FlushE  in  1  replace current EX instruction with bubble
ForwardAE  in  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUOutM
ForwardBE  in  2  SrcB-pre-imm select, same encoding
RD1E, RD2E  in  WIDTH  register operands from ID/EX
ExtImmE  in  WIDTH  extended immediate
ResultW  in  WIDTH  writeback result for forwarding
ALUSrcE  in  1  1 = SrcB is ExtImmE
ALUControlE  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
FlagWriteE  in  2  [1] write N,Z; [0] write C,V
CondE  in  4  ARM condition code
PCSrcE, RegWriteE, MemWriteE, MemToRegE, PlusOneE  in  1 each  control bits from ID/EX
WA3E  in  4  destination register
BusyE  out  1  combinational; upstream must hold ID/EX and IF/ID while high
ALUOutM, WriteDataM  out  WIDTH  registered ALU result / forwarded SrcB (pre-immediate)
WA3M  out  4  registered destination
PCSrcM, RegWriteM, MemWriteM, MemToRegM, PlusOneM  out  1 each  registered, condition-gated controls

Behaviour:
- Reset (reset==0 at clock edge):
  - All M outputs go to 0.
  - Flags NZCV = 0000, FSM = IDLE, BusyE = 0.
  - Reset has priority over everything and aborts an in-flight MUL.
- Latency: one cycle from EX inputs to M outputs. BusyE and the forwarding muxes are combinational.
- Arithmetic:
  - ADD/SUB use a 33-bit sum. SUB is A + ~B + 1.
  - C = bit 32 of the sum.
  - V = (A[31] == B'[31]) && (sum[31] != A[31]), where B' is the actual adder input.
  - AND/ORR leave C,V unchanged even when FlagWriteE[0] = 1.
  - N = result[31]; Z = (result == 0).
  - MUL keeps the low WIDTH bits of the product. It updates N,Z only; C,V are never written.
- Condition:
  - CondEx is evaluated on the flags as they stand before this instruction. Standard ARM encodings 0000 EQ through 1110 AL; 1111 is treated as AL.
  - If CondEx = 0: RegWriteM, MemWriteM and PCSrcM are forced to 0 and flags are not written. ALUOutM is still registered.
- Flush: FlushE = 1 loads a bubble (all M controls 0, data 0) and blocks any flag write. It overrides CondEx and the MUL FSM.
- MUL FSM:
  - IDLE:
    - A MUL with CondEx = 1 and no flush raises BusyE = 1.
    - Operands (post-forwarding) are captured into the multiplier register and the FSM goes to MUL1.
    - EX/MEM loads a bubble that cycle.
  - MUL1:
    - BusyE = 0.
    - The captured product, plus the controls held in ID/EX, are loaded into EX/MEM.
    - Flags are written if requested; FSM returns to IDLE.
  - FlushE in MUL1: bubble, no flag write, return to IDLE.
  - MUL with CondEx = 0: no stall; a single cycle with gated controls.
  - Back-to-back MULs each take 2 cycles.
- The ALUOutM forwarding path uses the registered ALUOutM value.
- When MUL_EN = 0: opcode 100 behaves as ADD and BusyE is tied to 0.

Decomposition:
- Package arm_pkg holds:
  - alu_op_t enum (ADD, SUB, AND, ORR, MUL)
  - cond_t enum for the 16 ARM codes
  - fwd_sel_t (RF, WB, MEM)
  - flags_t struct {n, z, c, v}
- One sub-module, cond_unit:
  - Inputs: CondE, current flags, FlagWriteE, ALU flags.
  - Outputs: CondEx and the next flags. It owns the flags register.
- ALU, forwarding muxes, FSM and EX/MEM register stay in execute_stage.

Test Plan:
1. ADD, RD1E = 5, RD2E = 7, ALUSrcE = 0, RegWriteE = 1, CondE = 1110 -> next cycle ALUOutM = 12, WriteDataM = 7, RegWriteM = 1, WA3M = WA3E.
2. SUB 3-3, FlagWriteE = 11 -> Z = 1, C = 1. Next instruction CondE = 0000 with MemWriteE = 1 -> MemWriteM = 1. Repeat with CondE = 0001 -> MemWriteM = 0, RegWriteM = 0, PCSrcM = 0.
3. ADD 0x7FFFFFFF + 1, FlagWriteE = 11 -> ALUOutM = 0x80000000, flags N = 1, Z = 0, C = 0, V = 1. A following VS-conditioned write executes; a VC-conditioned write is suppressed.
4. Forwarding:
   - ForwardAE = 10 with ALUOutM = 0x10 and RD1E = 0 -> operand A = 0x10.
   - ForwardBE = 01 with ResultW = 0x20 and ALUSrcE = 0 -> WriteDataM = 0x20.
   - ALUSrcE = 1 -> WriteDataM still 0x20, ALU uses ExtImmE.
5. MUL 6*7, FlagWriteE = 10 -> BusyE = 1 for exactly one cycle, M shows a bubble, then ALUOutM = 42, Z = 0. Repeat with FlushE = 1 in MUL1 -> bubble, no write, FSM in IDLE, BusyE = 0.
6. reset = 0 asserted during MUL1 -> at the next edge all M outputs = 0, NZCV = 0000, BusyE = 0. A subsequent ADD behaves per test 1.
